// File: rtl/hac_and2_cell.sv
// Two-input AND leaf cell with 3-valued inputs, LATENCY-deep (value, known) pipeline,
// and watch-event pulses and saturating counters on known output transitions.
module hac_and2_cell #(
  parameter string       PRSIM_NAME = "",
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             a_vld,
  input  logic             b,
  input  logic             b_vld,
  output logic             z,
  output logic             z_vld,
  output logic             z_rise,
  output logic             z_fall,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt
);

  localparam int unsigned LAST = LATENCY - 1;

  logic [LATENCY-1:0] val_q, val_d;
  logic [LATENCY-1:0] kn_q, kn_d;
  logic               prev_z_q, prev_z_d;
  logic               prev_vld_q, prev_vld_d;
  logic               z_rise_q, z_rise_d;
  logic               z_fall_q, z_fall_d;
  logic [CNT_W-1:0]   rise_cnt_q, rise_cnt_d;
  logic [CNT_W-1:0]   fall_cnt_q, fall_cnt_d;
  logic               s0_zero, s0_one;

  always_comb begin
    // A known zero on either input controls the output regardless of the other.
    s0_zero = (a_vld & ~a) | (b_vld & ~b);
    s0_one  = a_vld & b_vld & a & b;

    val_d    = '0;
    kn_d     = '0;
    val_d[0] = s0_one;
    kn_d[0]  = s0_zero | s0_one;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      val_d[i] = val_q[i-1];
      kn_d[i]  = kn_q[i-1];
    end

    prev_z_d   = val_q[LAST];
    prev_vld_d = kn_q[LAST];

    z_rise_d = prev_vld_q & ~prev_z_q & kn_q[LAST] &  val_q[LAST];
    z_fall_d = prev_vld_q &  prev_z_q & kn_q[LAST] & ~val_q[LAST];

    rise_cnt_d = rise_cnt_q;
    fall_cnt_d = fall_cnt_q;
    if (z_rise_d && (rise_cnt_q != '1)) rise_cnt_d = rise_cnt_q + CNT_W'(1);
    if (z_fall_d && (fall_cnt_q != '1)) fall_cnt_d = fall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q      <= '0;
      kn_q       <= '0;
      prev_z_q   <= 1'b0;
      prev_vld_q <= 1'b0;
      z_rise_q   <= 1'b0;
      z_fall_q   <= 1'b0;
      rise_cnt_q <= '0;
      fall_cnt_q <= '0;
    end else begin
      val_q      <= val_d;
      kn_q       <= kn_d;
      prev_z_q   <= prev_z_d;
      prev_vld_q <= prev_vld_d;
      z_rise_q   <= z_rise_d;
      z_fall_q   <= z_fall_d;
      rise_cnt_q <= rise_cnt_d;
      fall_cnt_q <= fall_cnt_d;
    end
  end

  assign z        = val_q[LAST];
  assign z_vld    = kn_q[LAST];
  assign z_rise   = z_rise_q;
  assign z_fall   = z_fall_q;
  assign rise_cnt = rise_cnt_q;
  assign fall_cnt = fall_cnt_q;

endmodule

// File: tb/tb_hac_and2_cell.sv
// Bench: 3-cell AND tree z=(a&b)&(c&d), a CNT_W=2 leaf and a LATENCY=3 leaf,
// checked against a queue-based scoreboard and a transition/counter model.
module tb_hac_and2_cell;

  typedef struct packed {
    logic z;
    logic v;
  } zv_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a = 1'b0, a_vld = 1'b0, b = 1'b0, b_vld = 1'b0;
  logic c = 1'b0, c_vld = 1'b0, d = 1'b0, d_vld = 1'b0;

  always #5 clk = ~clk;

  logic        ab_z, ab_v, ab_r, ab_f, cd_z, cd_v, cd_r, cd_f;
  logic [15:0] ab_rc, ab_fc, cd_rc, cd_fc;
  logic        t_z, t_v, t_r, t_f;
  logic [15:0] t_rc, t_fc;
  logic        s_z, s_v, s_r, s_f;
  logic [1:0]  s_rc, s_fc;
  logic        l_z, l_v, l_r, l_f;
  logic [15:0] l_rc, l_fc;

  hac_and2_cell #(.PRSIM_NAME("tree.and_ab")) u_ab (
    .clk(clk), .rst(rst), .a(a), .a_vld(a_vld), .b(b), .b_vld(b_vld),
    .z(ab_z), .z_vld(ab_v), .z_rise(ab_r), .z_fall(ab_f), .rise_cnt(ab_rc), .fall_cnt(ab_fc));
  hac_and2_cell #(.PRSIM_NAME("tree.and_cd")) u_cd (
    .clk(clk), .rst(rst), .a(c), .a_vld(c_vld), .b(d), .b_vld(d_vld),
    .z(cd_z), .z_vld(cd_v), .z_rise(cd_r), .z_fall(cd_f), .rise_cnt(cd_rc), .fall_cnt(cd_fc));
  hac_and2_cell #(.PRSIM_NAME("tree.and_root")) u_root (
    .clk(clk), .rst(rst), .a(ab_z), .a_vld(ab_v), .b(cd_z), .b_vld(cd_v),
    .z(t_z), .z_vld(t_v), .z_rise(t_r), .z_fall(t_f), .rise_cnt(t_rc), .fall_cnt(t_fc));
  hac_and2_cell #(.PRSIM_NAME("sat"), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .a(a), .a_vld(a_vld), .b(b), .b_vld(b_vld),
    .z(s_z), .z_vld(s_v), .z_rise(s_r), .z_fall(s_f), .rise_cnt(s_rc), .fall_cnt(s_fc));
  hac_and2_cell #(.PRSIM_NAME("lat3"), .LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst), .a(c), .a_vld(c_vld), .b(d), .b_vld(d_vld),
    .z(l_z), .z_vld(l_v), .z_rise(l_r), .z_fall(l_f), .rise_cnt(l_rc), .fall_cnt(l_fc));

  int n_chk  = 0;
  int n_fail = 0;

  zv_t q_tree[$];
  zv_t q_sat[$];
  zv_t q_lat[$];

  // Transition model per observed cell: 0 = tree root, 1 = sat leaf, 2 = lat3 leaf.
  zv_t p1[3];
  zv_t p2[3];
  int  m_rc[3];
  int  m_fc[3];
  int  cmax[3] = '{65535, 3, 65535};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic zv_t and3(logic x, logic xv, logic y, logic yv);
    zv_t r;
    r.z = 1'b0;
    r.v = 1'b0;
    if ((xv && !x) || (yv && !y)) r.v = 1'b1;
    else if (xv && yv && x && y) begin
      r.z = 1'b1;
      r.v = 1'b1;
    end
    return r;
  endfunction

  task automatic model_reset();
    zv_t zero;
    zero = '0;
    q_tree.delete();
    q_sat.delete();
    q_lat.delete();
    // Reset pipeline stages read as unknown until real samples arrive.
    q_tree.push_back(zero);
    q_lat.push_back(zero);
    q_lat.push_back(zero);
    for (int i = 0; i < 3; i++) begin
      p1[i] = zero;
      p2[i] = zero;
      m_rc[i] = 0;
      m_fc[i] = 0;
    end
  endtask

  task automatic observe(input int i, input string tg, input zv_t cur,
                         input logic dz, input logic dv, input logic dr, input logic df,
                         input int rc, input int fc);
    logic er, ef;
    er = p2[i].v && !p2[i].z && p1[i].v &&  p1[i].z;
    ef = p2[i].v &&  p2[i].z && p1[i].v && !p1[i].z;
    if (er && m_rc[i] < cmax[i]) m_rc[i]++;
    if (ef && m_fc[i] < cmax[i]) m_fc[i]++;
    chk({tg, ".z"},        32'(dz), 32'(cur.z));
    chk({tg, ".z_vld"},    32'(dv), 32'(cur.v));
    chk({tg, ".z_rise"},   32'(dr), 32'(er));
    chk({tg, ".z_fall"},   32'(df), 32'(ef));
    chk({tg, ".rise_cnt"}, 32'(rc), 32'(m_rc[i]));
    chk({tg, ".fall_cnt"}, 32'(fc), 32'(m_fc[i]));
    p2[i] = p1[i];
    p1[i] = cur;
  endtask

  task automatic cycle();
    zv_t eab, ecd;
    eab = and3(a, a_vld, b, b_vld);
    ecd = and3(c, c_vld, d, d_vld);
    q_sat.push_back(eab);
    q_lat.push_back(ecd);
    q_tree.push_back(and3(eab.z, eab.v, ecd.z, ecd.v));
    @(posedge clk);
    #1;
    observe(0, "tree", q_tree.pop_front(), t_z, t_v, t_r, t_f, 32'(t_rc), 32'(t_fc));
    observe(1, "sat",  q_sat.pop_front(),  s_z, s_v, s_r, s_f, 32'(s_rc), 32'(s_fc));
    observe(2, "lat3", q_lat.pop_front(),  l_z, l_v, l_r, l_f, 32'(l_rc), 32'(l_fc));
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.tree", 32'({t_z, t_v, t_r, t_f}), 32'(0));
    chk("rst.tree_cnt", 32'({t_rc, t_fc}), 32'(0));
    chk("rst.leaves", 32'({ab_z, ab_v, ab_r, ab_f, cd_z, cd_v, cd_r, cd_f}), 32'(0));
    chk("rst.leaf_cnt", 32'({ab_rc | ab_fc, cd_rc | cd_fc}), 32'(0));
    chk("rst.sat", 32'({s_z, s_v, s_r, s_f, s_rc, s_fc}), 32'(0));
    chk("rst.lat3", 32'({l_z, l_v, l_r, l_f}), 32'(0));
    chk("rst.lat3_cnt", 32'({l_rc, l_fc}), 32'(0));
    rst = 1'b0;
    model_reset();
  endtask

  task automatic set_all(input logic val, input logic vld);
    a = val; b = val; c = val; d = val;
    a_vld = vld; b_vld = vld; c_vld = vld; d_vld = vld;
  endtask

  task automatic rand_inputs();
    a = 1'($urandom_range(0, 1)); a_vld = ($urandom_range(0, 3) != 0);
    b = 1'($urandom_range(0, 1)); b_vld = ($urandom_range(0, 3) != 0);
    c = 1'($urandom_range(0, 1)); c_vld = ($urandom_range(0, 3) != 0);
    d = 1'($urandom_range(0, 1)); d_vld = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    set_all(1'b0, 1'b0);
    @(posedge clk);
    do_reset();

    run(3);
    chk("allx.z_vld", 32'(t_v), 32'(0));
    chk("allx.z", 32'(t_z), 32'(0));

    a_vld = 1'b1; a = 1'b0;
    cycle();
    chk("ctl0.leaf_vld", 32'(ab_v), 32'(1));
    chk("ctl0.leaf_z", 32'(ab_z), 32'(0));

    set_all(1'b0, 1'b1);
    run(3);
    chk("all0.z_vld", 32'(t_v), 32'(1));
    chk("all0.z", 32'(t_z), 32'(0));

    set_all(1'b1, 1'b1);
    run(3);
    chk("all1.z", 32'(t_z), 32'(1));
    chk("all1.rise_cnt", 32'(t_rc), 32'(1));

    a = 1'b0;
    run(3);
    chk("a0.z", 32'(t_z), 32'(0));
    chk("a0.fall_cnt", 32'(t_fc), 32'(1));

    d = 1'b0;
    run(3);
    chk("d0.z", 32'(t_z), 32'(0));
    chk("d0.cnts", 32'({t_rc, t_fc}), 32'({16'd1, 16'd1}));

    a = 1'b1;
    run(3);
    chk("a1.z", 32'(t_z), 32'(0));
    d = 1'b1;
    run(3);
    chk("d1.z", 32'(t_z), 32'(1));
    chk("d1.rise_cnt", 32'(t_rc), 32'(2));

    for (int i = 0; i < 5; i++) begin
      a = 1'b0;
      run(2);
      a = 1'b1;
      run(2);
    end
    run(2);
    chk("sat.rise_cnt", 32'(s_rc), 32'(3));
    chk("sat.fall_cnt", 32'(s_fc), 32'(3));
    chk("tree.rise_cnt7", 32'(t_rc), 32'(7));

    for (int i = 0; i < 40; i++) begin
      rand_inputs();
      cycle();
    end

    set_all(1'b1, 1'b1);
    run(3);
    a = 1'b0;
    cycle();
    a = 1'b1;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      rand_inputs();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
